// File: rtl/a09_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : a09_pkg
//  Description : Encodings shared by the A09 sequence controller and the
//                datapath blocks that consume its strobes and selects.
//  Revision    : 1.0 - initial release
// ============================================================================
package a09_pkg;

    // PC_Src select encodings, identical to what the sequencer drives
    localparam logic [1:0] PC_SRC_BRANCH = 2'b00;
    localparam logic [1:0] PC_SRC_RET    = 2'b01;
    localparam logic [1:0] PC_SRC_SRC1   = 2'b10;
    localparam logic [1:0] PC_SRC_RSVD   = 2'b11;

    // Level of an asserted (active-low) sequencer strobe
    localparam logic ASSERT_L = 1'b0;

endpackage
`default_nettype wire

// File: rtl/return_stack.sv
`default_nettype none
// ============================================================================
//  Module      : return_stack
//  Description : LIFO of return addresses with push, pop and simultaneous
//                swap, full/empty status and sticky overflow/underflow flags.
//                The occupancy count doubles as the write pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module return_stack #(
    parameter int AddrWidth  = 16,
    parameter int StackDepth = 4
) (
    input  logic                              Clk,
    input  logic                              Reset,      // synchronous, active-low
    input  logic                              clear,      // active-high soft clear
    input  logic                              push,
    input  logic                              pop,
    input  logic [AddrWidth-1:0]              push_data,
    output logic [AddrWidth-1:0]              top,
    output logic [$clog2(StackDepth):0]       cnt,
    output logic                              full,
    output logic                              empty,
    output logic                              ovf,
    output logic                              unf
);

    localparam int c_PTR_W = $clog2(StackDepth);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(StackDepth);

    logic [AddrWidth-1:0] r_mem [StackDepth];
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_ovf;
    logic                 r_unf;

    logic                 w_empty;
    logic                 w_full;
    logic [c_CNT_W-1:0]   w_cnt_m1;
    logic [c_PTR_W-1:0]   w_top_idx;
    logic                 w_wr_en;
    logic [c_PTR_W-1:0]   w_wr_idx;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 w_ovf_set;
    logic                 w_unf_set;

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == c_DEPTH);
    assign w_cnt_m1  = r_cnt - c_CNT_W'(1);
    assign w_top_idx = w_cnt_m1[c_PTR_W-1:0];

    // Decode the requested operation into a write, a count change and flag sets
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = r_cnt[c_PTR_W-1:0];
        w_cnt_nxt = r_cnt;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        if (push && pop) begin
            // Swap: overwrite the top in place; on empty it is a failed pop
            if (w_empty) begin
                w_unf_set = 1'b1;
            end else begin
                w_wr_en  = 1'b1;
                w_wr_idx = w_top_idx;
            end
        end else if (push) begin
            if (w_full) begin
                w_ovf_set = 1'b1;
            end else begin
                w_wr_en   = 1'b1;
                w_cnt_nxt = r_cnt + c_CNT_W'(1);
            end
        end else if (pop) begin
            if (w_empty) begin
                w_unf_set = 1'b1;
            end else begin
                w_cnt_nxt = w_cnt_m1;
            end
        end
    end

    // Count and sticky flags; reset and soft clear discard any operation
    always_ff @(posedge Clk) begin
        if (!Reset || clear) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_ovf <= r_ovf | w_ovf_set;
            r_unf <= r_unf | w_unf_set;
        end
    end

    // Entry storage is never cleared; it is unobservable while empty
    always_ff @(posedge Clk) begin
        if (Reset && !clear && w_wr_en) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

    assign top   = w_empty ? '0 : r_mem[w_top_idx];
    assign cnt   = r_cnt;
    assign full  = w_full;
    assign empty = w_empty;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit
//  Description : A09 program counter with branch-target adder, load-source
//                mux, increment/load priority and a return-address stack.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
    import a09_pkg::*;
#(
    parameter int AddrWidth   = 16,
    parameter int OffsetWidth = 10,
    parameter int StackDepth  = 4
) (
    input  logic                          Clk,
    input  logic                          Reset,     // synchronous, active-low
    input  logic                          PC_Rst,
    input  logic                          PC_Inc,
    input  logic                          PC_Ld,
    input  logic [1:0]                    PC_Src,
    input  logic                          BRA_Src,
    input  logic                          STK_Ld,
    input  logic [OffsetWidth-1:0]        Offset,
    input  logic [AddrWidth-1:0]          Src1,
    output logic [AddrWidth-1:0]          PC,
    output logic [AddrWidth-1:0]          RetAddr,
    output logic [$clog2(StackDepth):0]   StkCnt,
    output logic                          StkFull,
    output logic                          StkEmpty,
    output logic                          StkOvf,
    output logic                          StkUnf
);

    logic [AddrWidth-1:0] r_pc;
    logic [AddrWidth-1:0] w_pc_nxt;
    logic [AddrWidth-1:0] w_ld_val;
    logic [AddrWidth-1:0] w_offset_sext;
    logic [AddrWidth-1:0] w_branch_tgt;
    logic [AddrWidth-1:0] w_ret_addr;
    logic                 w_stk_empty;
    logic                 w_clear;
    logic                 w_ld;
    logic                 w_inc;
    logic                 w_push;
    logic                 w_pop;

    assign w_clear = (PC_Rst == ASSERT_L);
    assign w_ld    = (PC_Ld  == ASSERT_L);
    assign w_inc   = (PC_Inc == ASSERT_L);
    assign w_push  = (STK_Ld == ASSERT_L);
    assign w_pop   = w_ld && (PC_Src == PC_SRC_RET);

    // PC already points past the fetched instruction, so relative is from next
    assign w_offset_sext = {{(AddrWidth-OffsetWidth){Offset[OffsetWidth-1]}}, Offset};
    assign w_branch_tgt  = r_pc + w_offset_sext;

    // Load-source mux; a pop of an empty stack leaves PC where it is
    always_comb begin
        w_ld_val = r_pc;
        case (PC_Src)
            PC_SRC_BRANCH: w_ld_val = BRA_Src ? w_branch_tgt : Src1;
            PC_SRC_RET:    w_ld_val = w_stk_empty ? r_pc : w_ret_addr;
            PC_SRC_SRC1:   w_ld_val = Src1;
            default:       w_ld_val = r_pc;
        endcase
    end

    // Update priority: reset, soft clear, load, increment, hold
    always_comb begin
        w_pc_nxt = r_pc;
        if (!Reset || w_clear) begin
            w_pc_nxt = '0;
        end else if (w_ld) begin
            w_pc_nxt = w_ld_val;
        end else if (w_inc) begin
            w_pc_nxt = r_pc + AddrWidth'(1);
        end
    end

    // Program counter register
    always_ff @(posedge Clk) begin
        r_pc <= w_pc_nxt;
    end

    // The stack always records the pre-edge PC as the return address
    return_stack #(
        .AddrWidth  (AddrWidth),
        .StackDepth (StackDepth)
    ) u_return_stack (
        .Clk       (Clk),
        .Reset     (Reset),
        .clear     (w_clear),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (r_pc),
        .top       (w_ret_addr),
        .cnt       (StkCnt),
        .full      (StkFull),
        .empty     (w_stk_empty),
        .ovf       (StkOvf),
        .unf       (StkUnf)
    );

    assign PC       = r_pc;
    assign RetAddr  = w_ret_addr;
    assign StkEmpty = w_stk_empty;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_unit
//  Description : Self-checking bench for pc_unit: directed scenarios plus
//                random strobes compared against a queue-based stack model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

    logic        Clk = 1'b0;
    logic        Reset, PC_Rst, PC_Inc, PC_Ld, BRA_Src, STK_Ld;
    logic [1:0]  PC_Src;
    logic [9:0]  Offset;
    logic [15:0] Src1;
    logic [15:0] PC, RetAddr;
    logic [2:0]  StkCnt;
    logic        StkFull, StkEmpty, StkOvf, StkUnf;

    int errors = 0;
    int checks = 0;

    // Reference model: PC as an integer, stack as a queue (back = top)
    int m_pc = 0;
    int m_stk[$];
    bit m_ovf = 0;
    bit m_unf = 0;

    pc_unit #(.AddrWidth(16), .OffsetWidth(10), .StackDepth(4)) dut (
        .Clk(Clk), .Reset(Reset), .PC_Rst(PC_Rst), .PC_Inc(PC_Inc), .PC_Ld(PC_Ld),
        .PC_Src(PC_Src), .BRA_Src(BRA_Src), .STK_Ld(STK_Ld), .Offset(Offset),
        .Src1(Src1), .PC(PC), .RetAddr(RetAddr), .StkCnt(StkCnt), .StkFull(StkFull),
        .StkEmpty(StkEmpty), .StkOvf(StkOvf), .StkUnf(StkUnf)
    );

    always #5 Clk = ~Clk;

    function automatic int model_ret();
        return (m_stk.size() == 0) ? 0 : m_stk[$];
    endfunction

    // Apply the architectural rules for one edge to the model
    task automatic model_step();
        int  nxt;
        int  off;
        bit  push, pop;
        if (!Reset || !PC_Rst) begin
            m_pc = 0;
            m_stk.delete();
            m_ovf = 0;
            m_unf = 0;
            return;
        end
        push = !STK_Ld;
        pop  = !PC_Ld && PC_Src == 2'b01;
        off  = (Offset >= 10'd512) ? int'(Offset) - 1024 : int'(Offset);
        nxt  = m_pc;
        if (!PC_Ld) begin
            case (PC_Src)
                2'b00: nxt = BRA_Src ? ((m_pc + off) & 16'hFFFF) : int'(Src1);
                2'b01: nxt = (m_stk.size() > 0) ? m_stk[$] : m_pc;
                2'b10: nxt = int'(Src1);
                default: nxt = m_pc;
            endcase
        end else if (!PC_Inc) begin
            nxt = (m_pc + 1) & 16'hFFFF;
        end
        if (push && pop) begin
            if (m_stk.size() == 0) m_unf = 1;
            else m_stk[m_stk.size()-1] = m_pc;
        end else if (push) begin
            if (m_stk.size() == 4) m_ovf = 1;
            else m_stk.push_back(m_pc);
        end else if (pop) begin
            if (m_stk.size() == 0) m_unf = 1;
            else void'(m_stk.pop_back());
        end
        m_pc = nxt;
    endtask

    task automatic idle();
        Reset = 1; PC_Rst = 1; PC_Inc = 1; PC_Ld = 1; STK_Ld = 1;
        PC_Src = 2'b11; BRA_Src = 0; Offset = '0; Src1 = '0;
    endtask

    // One clock: model follows the driven inputs, outputs sampled 1ns later
    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
        idle();
    endtask

    task automatic load(input logic [15:0] v);
        PC_Ld = 0; PC_Src = 2'b10; Src1 = v;
        tick();
    endtask

    task automatic test_reset();
        Reset = 0; PC_Inc = 0; tick();
        Reset = 0; PC_Inc = 0; tick();
        checks++; if (PC !== 16'h0) begin errors++; $display("FAIL reset_pc: got %h want 0000", PC); end
        checks++; if (StkCnt !== 3'd0 || StkEmpty !== 1'b1 || StkFull !== 1'b0) begin
            errors++; $display("FAIL reset_stk: cnt=%0d empty=%b full=%b want 0/1/0", StkCnt, StkEmpty, StkFull); end
        checks++; if (StkOvf !== 1'b0 || StkUnf !== 1'b0 || RetAddr !== 16'h0) begin
            errors++; $display("FAIL reset_flags: ovf=%b unf=%b ret=%h want 0/0/0000", StkOvf, StkUnf, RetAddr); end
        for (int i = 0; i < 3; i++) begin
            PC_Inc = 0; tick();
            tick();
        end
        checks++; if (PC !== 16'h3) begin errors++; $display("FAIL inc3: got %h want 0003", PC); end
    endtask

    task automatic test_wrap_branch();
        load(16'hFFFF);
        checks++; if (PC !== 16'hFFFF) begin errors++; $display("FAIL load_src1: got %h want ffff", PC); end
        PC_Inc = 0; tick();
        checks++; if (PC !== 16'h0000) begin errors++; $display("FAIL inc_wrap: got %h want 0000", PC); end
        load(16'h0010);
        PC_Ld = 0; PC_Src = 2'b00; BRA_Src = 1; Offset = 10'h3FD; tick();
        checks++; if (PC !== 16'h000D) begin errors++; $display("FAIL bra_neg: got %h want 000d", PC); end
        load(16'h0010);
        PC_Ld = 0; PC_Src = 2'b00; BRA_Src = 1; Offset = 10'h1FF; tick();
        checks++; if (PC !== 16'h020F) begin errors++; $display("FAIL bra_pos: got %h want 020f", PC); end
        PC_Ld = 0; PC_Src = 2'b00; BRA_Src = 0; Src1 = 16'hBEEF; tick();
        checks++; if (PC !== 16'hBEEF) begin errors++; $display("FAIL bra_abs: got %h want beef", PC); end
        load(16'h0002);
        PC_Ld = 0; PC_Src = 2'b00; BRA_Src = 1; Offset = 10'h200; tick();
        checks++; if (PC !== 16'hFE02) begin errors++; $display("FAIL bra_wrap: got %h want fe02", PC); end
    endtask

    task automatic test_jpl_ret();
        load(16'h0021);
        PC_Ld = 0; PC_Src = 2'b10; Src1 = 16'h0100; STK_Ld = 0; tick();
        checks++; if (PC !== 16'h0100 || RetAddr !== 16'h0021 || StkCnt !== 3'd1) begin
            errors++; $display("FAIL jpl: pc=%h ret=%h cnt=%0d want 0100/0021/1", PC, RetAddr, StkCnt); end
        PC_Ld = 0; PC_Src = 2'b01; tick();
        checks++; if (PC !== 16'h0021 || StkEmpty !== 1'b1 || RetAddr !== 16'h0) begin
            errors++; $display("FAIL ret: pc=%h empty=%b ret=%h want 0021/1/0000", PC, StkEmpty, RetAddr); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            load(16'(16'h0011 + i));
            STK_Ld = 0; tick();
        end
        checks++; if (StkCnt !== 3'd4 || StkFull !== 1'b1 || StkOvf !== 1'b1 || RetAddr !== 16'h0014) begin
            errors++; $display("FAIL ovf: cnt=%0d full=%b ovf=%b ret=%h want 4/1/1/0014", StkCnt, StkFull, StkOvf, RetAddr); end
        for (int k = 0; k < 4; k++) begin
            PC_Ld = 0; PC_Src = 2'b01; tick();
            checks++; if (PC !== 16'(16'h0014 - k)) begin
                errors++; $display("FAIL pop%0d: got %h want %h", k, PC, 16'(16'h0014 - k)); end
        end
        checks++; if (StkOvf !== 1'b1 || StkEmpty !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky: ovf=%b empty=%b want 1/1", StkOvf, StkEmpty); end
        PC_Rst = 0; tick();
        checks++; if (StkOvf !== 1'b0 || PC !== 16'h0) begin
            errors++; $display("FAIL ovf_clear: ovf=%b pc=%h want 0/0000", StkOvf, PC); end
    endtask

    task automatic test_underflow_swap();
        load(16'h0077);
        PC_Ld = 0; PC_Src = 2'b01; tick();
        checks++; if (PC !== 16'h0077 || StkUnf !== 1'b1) begin
            errors++; $display("FAIL unf: pc=%h unf=%b want 0077/1", PC, StkUnf); end
        tick();
        checks++; if (StkUnf !== 1'b1) begin errors++; $display("FAIL unf_sticky: got %b want 1", StkUnf); end
        load(16'h0040);
        STK_Ld = 0; tick();
        load(16'h0050);
        PC_Ld = 0; PC_Src = 2'b01; STK_Ld = 0; tick();
        checks++; if (PC !== 16'h0040 || RetAddr !== 16'h0050 || StkCnt !== 3'd1) begin
            errors++; $display("FAIL swap: pc=%h ret=%h cnt=%0d want 0040/0050/1", PC, RetAddr, StkCnt); end
        PC_Rst = 0; tick();
        checks++; if (StkUnf !== 1'b0) begin errors++; $display("FAIL unf_clear: got %b want 0", StkUnf); end
        load(16'h0060);
        PC_Ld = 0; PC_Src = 2'b01; STK_Ld = 0; tick();
        checks++; if (PC !== 16'h0060 || StkUnf !== 1'b1 || StkCnt !== 3'd0) begin
            errors++; $display("FAIL swap_empty: pc=%h unf=%b cnt=%0d want 0060/1/0", PC, StkUnf, StkCnt); end
    endtask

    task automatic test_priority();
        load(16'h0033);
        PC_Rst = 0; PC_Ld = 0; PC_Src = 2'b10; Src1 = 16'h1234; STK_Ld = 0; tick();
        checks++; if (PC !== 16'h0 || StkCnt !== 3'd0 || StkUnf !== 1'b0) begin
            errors++; $display("FAIL rst_prio: pc=%h cnt=%0d unf=%b want 0000/0/0", PC, StkCnt, StkUnf); end
        PC_Ld = 0; PC_Inc = 0; PC_Src = 2'b10; Src1 = 16'h0500; tick();
        checks++; if (PC !== 16'h0500) begin errors++; $display("FAIL ld_over_inc: got %h want 0500", PC); end
        PC_Ld = 0; PC_Inc = 0; PC_Src = 2'b11; tick();
        checks++; if (PC !== 16'h0500 || StkUnf !== 1'b0) begin
            errors++; $display("FAIL rsvd_hold: pc=%h unf=%b want 0500/0", PC, StkUnf); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            Reset   = ($urandom_range(63) != 0);
            PC_Rst  = ($urandom_range(31) != 0);
            PC_Inc  = $urandom_range(1);
            PC_Ld   = ($urandom_range(2) != 0);
            STK_Ld  = ($urandom_range(2) != 0);
            PC_Src  = 2'($urandom_range(3));
            BRA_Src = $urandom_range(1);
            Offset  = 10'($urandom);
            Src1    = 16'($urandom);
            tick();
            checks++;
            if (PC !== 16'(m_pc) || RetAddr !== 16'(model_ret()) || StkCnt !== 3'(m_stk.size())
                || StkFull !== (m_stk.size() == 4) || StkEmpty !== (m_stk.size() == 0)
                || StkOvf !== m_ovf || StkUnf !== m_unf) begin
                errors++;
                $display("FAIL rand%0d: pc=%h ret=%h cnt=%0d ovf=%b unf=%b want %h/%h/%0d/%b/%b",
                         i, PC, RetAddr, StkCnt, StkOvf, StkUnf, 16'(m_pc), 16'(model_ret()),
                         m_stk.size(), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        idle();
        #2;
        test_reset();
        test_wrap_branch();
        test_jpl_ret();
        test_overflow();
        test_underflow_swap();
        test_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_unit.md
# pc_unit

Program counter and return-address stack for the A09 datapath. It sits directly downstream of the sequence controller and consumes its active-low PC_Rst, PC_Inc, PC_Ld and STK_Ld strobes plus the PC_Src and BRA_Src selects. It produces the instruction fetch address and the RET target. Branch targets are either PC-relative from the IR offset field or absolute from register-file Source 1.

## Interface
- AddrWidth, 16: PC, stack entry and Src1 width.
- OffsetWidth, 10: IR branch offset width (IR[9:0]), sign-extended.
- StackDepth, 4: return-stack entries (power of 2, ≥2).
- Clk  in  1  clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-low; clock Clk.
- PC_Rst  in  1  active-low; clear PC and stack.
- PC_Inc  in  1  active-low; PC <= PC+1.
- PC_Ld  in  1  active-low; PC <= selected source.
- PC_Src  in  2  00 branch target, 01 stack pop, 10 Src1, 11 reserved (hold).
- BRA_Src  in  1  branch target select: 1 PC+sext(Offset), 0 Src1.
- STK_Ld  in  1  active-low; push current PC.
- Offset  in  OffsetWidth  IR[9:0].
- Src1  in  AddrWidth  register-file Source 1 data.
- PC  out  AddrWidth  registered program counter.
- RetAddr  out  AddrWidth  top of stack; 0 when empty.
- StkCnt  out  $clog2(StackDepth)+1  occupied entries.
- StkFull, StkEmpty  out  1 each  from StkCnt.
- StkOvf, StkUnf  out  1 each  sticky error flags.

## Operation
- Reset values (Reset low or PC_Rst low): PC=0, StkCnt=0, StkEmpty=1, StkFull=0, StkOvf=0, StkUnf=0, RetAddr=0. Stack storage is not cleared; it is unobservable while empty.
- PC update priority: Reset > PC_Rst > PC_Ld > PC_Inc > hold.
- PC_Ld sources:
  - 00: BRA_Src=1 gives PC + sext(Offset), mod 2^AddrWidth. BRA_Src=0 gives Src1.
  - 01: RetAddr, with a pop.
  - 10: Src1.
  - 11: hold PC, no error.
- PC is the value present at the edge. The sequencer has already incremented it past the fetched instruction, so relative branches are from next-instruction address.
- Increment wraps: all-ones -> 0.
- Push (STK_Ld low): the stack stores the pre-edge PC, i.e. the return address. Push may coincide with PC_Ld (JPL). The stored value is always the old PC.
- Pop occurs only when PC_Ld=0 and PC_Src=01.
- Push when full: write dropped, StkCnt unchanged, StkOvf <= 1, PC update still occurs.
- Pop when empty: PC holds, StkUnf <= 1.
- Simultaneous push and pop: PC <= old top, top entry <= old PC, StkCnt unchanged. This applies on empty too, where it acts as a pop of an empty stack: PC holds, StkUnf <= 1, and the push is dropped.
- PC_Inc together with PC_Ld: PC_Ld wins.
- Sticky flags clear only on Reset or PC_Rst.
- Inputs are treated as level-valid at each edge. There is no handshake; the sequencer guarantees one-cycle strobes.

## Timing
- All outputs are registered or derived combinationally from registers, so there is no input-to-output combinational path.
- PC, StkCnt and flags update 1 cycle after strobe sampling.
- RetAddr reflects the new top in the same cycle StkCnt updates.
- Reset or PC_Rst mid-operation (e.g. coincident with push/pop): reset wins, and the push/pop is discarded.
- Throughput: one PC update plus one stack operation per cycle.

## Structure
- Shared package a09_pkg:
  - PC_SRC_BRANCH=2'b00, PC_SRC_RET=2'b01, PC_SRC_SRC1=2'b10.
  - ASSERT_L=1'b0.
  - The same encodings the sequencer drives.
- Sub-module return_stack:
  - Register array, pointer, count, push/pop/swap logic, full/empty, sticky error flags.
  - Parameters AddrWidth and StackDepth.
- pc_unit top holds the PC register, target adder/sign-extension, source mux and priority logic.

## Test plan
- Reset: hold Reset low 2 cycles with PC_Inc low. Then PC=0, StkCnt=0, StkEmpty=1, all flags 0. Release and pulse PC_Inc 3 times: PC=3.
- Wrap and relative branch:
  - Load PC=0xFFFF via Src1, pulse PC_Inc: PC=0x0000.
  - With PC=0x0010, PC_Ld low, PC_Src=00, BRA_Src=1, Offset=10'h3FD: PC=0x000D.
  - Offset=10'h1FF: PC=0x020F.
- JPL/RET: with PC=0x0021, PC_Ld low, PC_Src=10, Src1=0x0100, STK_Ld low. Then PC=0x0100, RetAddr=0x0021, StkCnt=1. Next, PC_Ld low with PC_Src=01: PC=0x0021, StkEmpty=1.
- Overflow: 5 pushes with PC=0x11..0x15. Then StkCnt=4, StkFull=1, StkOvf=1, RetAddr=0x14. Pops return 0x14, 0x13, 0x12, 0x11.
- Underflow and swap:
  - Pop on empty: PC unchanged, StkUnf=1 until PC_Rst.
  - With top=0x0040 and PC=0x0050, push+pop together: PC=0x0040, RetAddr=0x0050, StkCnt unchanged.
- Priority: PC_Rst low with PC_Ld and STK_Ld low at PC=0x0033. Then PC=0, StkCnt=0, no push recorded.
